reorder_buffer: RTL

//  In-order retirement buffer between dispatch and the tagged register file. Dispatcher allocates one

---
 rtl/reorder_buffer_pkg.sv | 34 +++
 rtl/reorder_buffer_if.sv | 53 +++++
 rtl/reorder_buffer_query.sv | 43 ++++
 rtl/reorder_buffer.sv | 137 +++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared widths, bus types and index helpers for the reorder buffer slice.
// Tag 0 is reserved as "free"; entry i is addressed externally by tag i+1.
package reorder_buffer_pkg;

    localparam int unsigned TAG_W  = 4;
    localparam int unsigned DEPTH  = (1 << TAG_W) - 1;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NAME_W = 5;

    typedef logic [TAG_W-1:0]  tag_t;
    typedef logic [NAME_W-1:0] name_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic              enable_t;
    typedef logic [TAG_W-1:0]  idx_t;
    typedef logic [TAG_W-1:0]  cnt_t;

    localparam tag_t  TAG_FREE  = '0;
    localparam data_t DATA_FREE = '0;
    localparam idx_t  LAST_IDX  = idx_t'(DEPTH - 1);
    localparam cnt_t  FULL_CNT  = cnt_t'(DEPTH);

    function automatic idx_t idx_inc(input idx_t i);
        return (i == LAST_IDX) ? '0 : i + idx_t'(1);
    endfunction

    function automatic tag_t idx2tag(input idx_t i);
        return tag_t'(i + idx_t'(1));
    endfunction

    function automatic idx_t tag2idx(input tag_t t);
        return idx_t'(t - tag_t'(1));
    endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch / CDB / query / retire signal bundle of the reorder buffer.
// master = surrounding pipeline side, slave = the reorder buffer itself.
interface reorder_buffer_if;
    import reorder_buffer_pkg::*;

    logic    flush;
    enable_t alloc_en;
    name_t   alloc_name;
    logic    alloc_rdy;
    tag_t    alloc_tag;

    enable_t cdbA_en;
    tag_t    cdbA_tag;
    data_t   cdbA_data;
    enable_t cdbL_en;
    tag_t    cdbL_tag;
    data_t   cdbL_data;

    tag_t    q0_tag;
    tag_t    q1_tag;
    logic    q0_rdy;
    data_t   q0_data;
    logic    q1_rdy;
    data_t   q1_data;

    enable_t cmt0_en;
    name_t   cmt0_name;
    tag_t    cmt0_tag;
    data_t   cmt0_data;
    enable_t cmt1_en;
    name_t   cmt1_name;
    tag_t    cmt1_tag;
    data_t   cmt1_data;

    modport master (
        output flush, alloc_en, alloc_name,
        output cdbA_en, cdbA_tag, cdbA_data, cdbL_en, cdbL_tag, cdbL_data,
        output q0_tag, q1_tag,
        input  alloc_rdy, alloc_tag, q0_rdy, q0_data, q1_rdy, q1_data,
        input  cmt0_en, cmt0_name, cmt0_tag, cmt0_data,
        input  cmt1_en, cmt1_name, cmt1_tag, cmt1_data
    );

    modport slave (
        input  flush, alloc_en, alloc_name,
        input  cdbA_en, cdbA_tag, cdbA_data, cdbL_en, cdbL_tag, cdbL_data,
        input  q0_tag, q1_tag,
        output alloc_rdy, alloc_tag, q0_rdy, q0_data, q1_rdy, q1_data,
        output cmt0_en, cmt0_name, cmt0_tag, cmt0_data,
        output cmt1_en, cmt1_name, cmt1_tag, cmt1_data
    );

endinterface

// File: rtl/reorder_buffer_query.sv
// Operand lookup for dispatch: completed entry first, then same-cycle CDB bypass
// (ALU ahead of LS). Tag 0 means "no producer" and is always ready with zero data.
module rob_query
    import reorder_buffer_pkg::*;
(
    input  logic             rst,
    input  tag_t             q_tag,
    input  logic [DEPTH-1:0] entry_valid,
    input  logic [DEPTH-1:0] entry_ready,
    input  data_t            entry_data [DEPTH],
    input  enable_t          cdba_en,
    input  tag_t             cdba_tag,
    input  data_t            cdba_data,
    input  enable_t          cdbl_en,
    input  tag_t             cdbl_tag,
    input  data_t            cdbl_data,
    output logic             q_rdy,
    output data_t            q_data
);

    idx_t idx;

    always_comb begin
        idx    = tag2idx(q_tag);
        q_rdy  = 1'b0;
        q_data = DATA_FREE;
        if (!rst) begin
            if (q_tag == TAG_FREE) begin
                q_rdy = 1'b1;
            end else if (entry_valid[idx] && entry_ready[idx]) begin
                q_rdy  = 1'b1;
                q_data = entry_data[idx];
            end else if (cdba_en && cdba_tag == q_tag) begin
                q_rdy  = 1'b1;
                q_data = cdba_data;
            end else if (cdbl_en && cdbl_tag == q_tag) begin
                q_rdy  = 1'b1;
                q_data = cdbl_data;
            end
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: one allocation per cycle, CDB completion marking,
// up to two in-order retires per cycle, and two operand lookup ports.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    reorder_buffer_if.slave bus
);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] ready_q, ready_d;
    name_t            name_q [DEPTH];
    name_t            name_d [DEPTH];
    data_t            data_q [DEPTH];
    data_t            data_d [DEPTH];
    idx_t             head_q, head_d;
    idx_t             tail_q, tail_d;
    cnt_t             count_q, count_d;

    idx_t head1;
    logic alloc_rdy, alloc_fire, cmt0, cmt1;
    logic cdba_hit, cdbl_hit;
    idx_t cdba_idx, cdbl_idx;

    always_comb begin
        head1      = idx_inc(head_q);
        alloc_rdy  = (count_q < FULL_CNT) & ~bus.flush & ~rst;
        alloc_fire = alloc_rdy & bus.alloc_en;
        cmt0       = valid_q[head_q] & ready_q[head_q] & ~bus.flush & ~rst;
        cmt1       = cmt0 & valid_q[head1] & ready_q[head1];
        cdba_idx   = tag2idx(bus.cdbA_tag);
        cdbl_idx   = tag2idx(bus.cdbL_tag);
        // A slot being allocated this cycle is still invalid, so it can never be marked here.
        cdba_hit   = bus.cdbA_en & (bus.cdbA_tag != TAG_FREE) & valid_q[cdba_idx];
        cdbl_hit   = bus.cdbL_en & (bus.cdbL_tag != TAG_FREE) & valid_q[cdbl_idx];
    end

    always_comb begin
        bus.alloc_rdy = alloc_rdy;
        bus.alloc_tag = rst ? TAG_FREE : idx2tag(tail_q);
        bus.cmt0_en   = cmt0;
        bus.cmt0_name = cmt0 ? name_q[head_q] : '0;
        bus.cmt0_tag  = cmt0 ? idx2tag(head_q) : TAG_FREE;
        bus.cmt0_data = cmt0 ? data_q[head_q] : DATA_FREE;
        bus.cmt1_en   = cmt1;
        bus.cmt1_name = cmt1 ? name_q[head1] : '0;
        bus.cmt1_tag  = cmt1 ? idx2tag(head1) : TAG_FREE;
        bus.cmt1_data = cmt1 ? data_q[head1] : DATA_FREE;
    end

    always_comb begin
        valid_d = valid_q;
        ready_d = ready_q;
        name_d  = name_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rst || bus.flush) begin
            valid_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            if (rst) begin
                ready_d = '0;
            end
        end else begin
            if (alloc_fire) begin
                valid_d[tail_q] = 1'b1;
                ready_d[tail_q] = 1'b0;
                name_d[tail_q]  = bus.alloc_name;
                tail_d          = idx_inc(tail_q);
            end
            // LS is applied first so an ALU broadcast of the same tag overrides it.
            if (cdbl_hit) begin
                ready_d[cdbl_idx] = 1'b1;
                data_d[cdbl_idx]  = bus.cdbL_data;
            end
            if (cdba_hit) begin
                ready_d[cdba_idx] = 1'b1;
                data_d[cdba_idx]  = bus.cdbA_data;
            end
            if (cmt0) begin
                valid_d[head_q] = 1'b0;
            end
            if (cmt1) begin
                valid_d[head1] = 1'b0;
            end
            head_d  = cmt1 ? idx_inc(head1) : (cmt0 ? head1 : head_q);
            count_d = count_q + cnt_t'(alloc_fire) - cnt_t'(cmt0) - cnt_t'(cmt1);
        end
    end

    always_ff @(posedge clk) begin
        valid_q <= valid_d;
        ready_q <= ready_d;
        name_q  <= name_d;
        data_q  <= data_d;
        head_q  <= head_d;
        tail_q  <= tail_d;
        count_q <= count_d;
    end

    rob_query u_q0 (
        .rst         (rst),
        .q_tag       (bus.q0_tag),
        .entry_valid (valid_q),
        .entry_ready (ready_q),
        .entry_data  (data_q),
        .cdba_en     (bus.cdbA_en),
        .cdba_tag    (bus.cdbA_tag),
        .cdba_data   (bus.cdbA_data),
        .cdbl_en     (bus.cdbL_en),
        .cdbl_tag    (bus.cdbL_tag),
        .cdbl_data   (bus.cdbL_data),
        .q_rdy       (bus.q0_rdy),
        .q_data      (bus.q0_data)
    );

    rob_query u_q1 (
        .rst         (rst),
        .q_tag       (bus.q1_tag),
        .entry_valid (valid_q),
        .entry_ready (ready_q),
        .entry_data  (data_q),
        .cdba_en     (bus.cdbA_en),
        .cdba_tag    (bus.cdbA_tag),
        .cdba_data   (bus.cdbA_data),
        .cdbl_en     (bus.cdbL_en),
        .cdbl_tag    (bus.cdbL_tag),
        .cdbl_data   (bus.cdbL_data),
        .q_rdy       (bus.q1_rdy),
        .q_data      (bus.q1_data)
    );

endmodule
